// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states, fetch geometry, FIFO entry.
// The HALT state exists only when IFETCH_ALIGN_CHECK_EN is defined.
package ifetch_pkg;

   localparam int BYTES_PER_INST = 4;

   typedef enum logic [1:0] {
      ST_ISSUE,
      ST_STALL
`ifdef IFETCH_ALIGN_CHECK_EN
      ,ST_HALT
`endif
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } fetch_entry_t;

endpackage

// File: rtl/ifetch_if.sv
// Redirect, byte-memory and instruction-delivery signals of the fetch sequencer.
// master = sequencer side, slave = core/memory side.
interface ifetch_if #(
   parameter int ADDR_W = 16
);
   logic              redirect_valid;
   logic [31:0]       redirect_pc;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       inst_data;
   logic [31:0]       inst_pc;
   logic              misalign_err;

   modport master (
      input  redirect_valid, redirect_pc, mem_rdata, inst_ready,
      output mem_rd, mem_addr, inst_valid, inst_data, inst_pc, misalign_err
   );

   modport slave (
      output redirect_valid, redirect_pc, mem_rdata, inst_ready,
      input  mem_rd, mem_addr, inst_valid, inst_data, inst_pc, misalign_err
   );
endinterface

// File: rtl/ifetch_fifo.sv
// DEPTH-entry synchronous prefetch FIFO with clear; push into a full FIFO is accepted
// only together with a pop. Head reads as zero while empty.
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  fetch_entry_t               din,
   output fetch_entry_t               dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] wr_q;
   logic [PW-1:0] rd_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      ptr_next = (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign count   = count_q;
   assign do_push = push && (!full || pop) && !clear;
   assign do_pop  = pop && !empty && !clear;
   assign dout    = empty ? '0 : mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= ptr_next(wr_q);
         if (do_pop)  rd_q <= ptr_next(rd_q);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/ifetch_sequencer.sv
// Instruction-fetch sequencer: four big-endian byte reads per word into a prefetch FIFO.
// Build option IFETCH_ALIGN_CHECK_EN: misaligned redirects set misalign_err and halt fetch.
module ifetch_sequencer
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 16,
   parameter int          DEPTH    = 2
) (
   input logic      clk,
   input logic      rst,
   ifetch_if.master bus
);

   localparam int CW = $clog2(DEPTH + 1);

   state_t            state_q;
   logic [1:0]        bcnt_q;
   logic [31:0]       fpc_q;
   logic [CW-1:0]     inflight_q;
   logic              mem_rd_p0;
   logic [ADDR_W-1:0] mem_addr_p0;
   logic [1:0]        bidx_p0;
   logic [31:0]       pc_p0;
   logic              vld_p1;
   logic [1:0]        bidx_p1;
   logic [31:0]       pc_p1;
   logic [31:8]       asm_p1;

   logic              issue;
   logic [1:0]        issue_k;
   logic [31:0]       issue_pc;
   logic              can_issue;
   logic              push;
   logic              pop;
   logic              misaligned;
   logic              halted;
   fetch_entry_t      push_entry;
   fetch_entry_t      head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;

   function automatic logic [ADDR_W-1:0] byte_addr(input logic [ADDR_W-3:0] wpc,
                                                   input logic [1:0] k);
      byte_addr = {wpc, k};
   endfunction

`ifdef IFETCH_ALIGN_CHECK_EN
   logic misalign_q;
   assign misaligned       = (bus.redirect_pc[1:0] != 2'b00);
   assign halted           = (state_q == ST_HALT);
   assign bus.misalign_err = misalign_q;

   always_ff @(posedge clk) begin
      if (rst)                     misalign_q <= 1'b0;
      else if (bus.redirect_valid) misalign_q <= misaligned;
   end
`else
   assign misaligned       = 1'b0;
   assign halted           = 1'b0;
   assign bus.misalign_err = 1'b0;
`endif

   // A new word may start only if everything already promised fits in the buffer.
   assign can_issue  = ({1'b0, fifo_count} + {1'b0, inflight_q}) < (CW + 1)'(DEPTH);
   assign push       = vld_p1 && (bidx_p1 == 2'd3) && !bus.redirect_valid;
   assign pop        = !fifo_empty && bus.inst_ready;
   assign push_entry = '{pc: pc_p1, data: {asm_p1, bus.mem_rdata}};

   always_comb begin
      issue    = 1'b0;
      issue_k  = bcnt_q;
      issue_pc = fpc_q;
      if (bus.redirect_valid) begin
         issue    = !misaligned;
         issue_k  = 2'd0;
         issue_pc = bus.redirect_pc & ~32'h3;
      end else if (!halted) begin
         issue = (bcnt_q != 2'd0) || can_issue;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_ISSUE;
         bcnt_q      <= 2'd0;
         fpc_q       <= RESET_PC;
         inflight_q  <= '0;
         mem_rd_p0   <= 1'b0;
         mem_addr_p0 <= '0;
         vld_p1      <= 1'b0;
      end else begin
         mem_rd_p0 <= issue;
         if (issue) mem_addr_p0 <= byte_addr(issue_pc[ADDR_W-1:2], issue_k);
         // The byte returning in the cycle after a redirect belongs to the old stream.
         vld_p1 <= mem_rd_p0 && !bus.redirect_valid;
         if (bus.redirect_valid) begin
            fpc_q      <= issue_pc;
            bcnt_q     <= issue ? 2'd1 : 2'd0;
            inflight_q <= issue ? CW'(1) : '0;
`ifdef IFETCH_ALIGN_CHECK_EN
            state_q    <= misaligned ? ST_HALT : ST_ISSUE;
`else
            state_q    <= ST_ISSUE;
`endif
         end else begin
            if (issue) begin
               bcnt_q  <= bcnt_q + 2'd1;
               state_q <= ST_ISSUE;
               if (bcnt_q == 2'd3) fpc_q <= fpc_q + 32'd4;
            end else if (!halted) begin
               state_q <= ST_STALL;
            end
            case ({issue && (bcnt_q == 2'd0), push})
               2'b10:   inflight_q <= inflight_q + CW'(1);
               2'b01:   inflight_q <= inflight_q - CW'(1);
               default: inflight_q <= inflight_q;
            endcase
         end
      end
   end

   // p0 -> p1: tag travels with the read; p1: byte lands in the assembly register
   always_ff @(posedge clk) begin
      if (issue) begin
         bidx_p0 <= issue_k;
         pc_p0   <= issue_pc & ~32'h3;
      end
      bidx_p1 <= bidx_p0;
      pc_p1   <= pc_p0;
      if (bus.redirect_valid) begin
         asm_p1 <= '0;
      end else if (vld_p1) begin
         case (bidx_p1)
            2'd0:    asm_p1[31:24] <= bus.mem_rdata;
            2'd1:    asm_p1[23:16] <= bus.mem_rdata;
            2'd2:    asm_p1[15:8]  <= bus.mem_rdata;
            default: asm_p1        <= asm_p1;
         endcase
      end
   end

   ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.redirect_valid),
      .push  (push),
      .pop   (pop),
      .din   (push_entry),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign bus.mem_rd     = mem_rd_p0;
   assign bus.mem_addr   = mem_addr_p0;
   assign bus.inst_valid = !fifo_empty;
   assign bus.inst_data  = head.data;
   assign bus.inst_pc    = head.pc;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Bench for ifetch_sequencer: directed timing steps plus a randomized phase; every delivered
// word is compared against the instruction stream predicted from the byte memory.
module tb_ifetch_sequencer;

   localparam int ADDR_W = 16;
   localparam int DEPTH  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ifetch_if #(.ADDR_W(ADDR_W)) bus ();

   ifetch_sequencer #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem [1 << ADDR_W];

   always @(posedge clk) begin
      if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
   end

   int          tests = 0;
   int          fails = 0;
   int          hs_count = 0;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] last_pc = 32'h0;

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_word(input logic [31:0] pc);
      logic [ADDR_W-1:0] b;
      b = pc[ADDR_W-1:0];
      b[1:0] = 2'b00;
      ref_word = {mem[b], mem[b + ADDR_W'(1)], mem[b + ADDR_W'(2)], mem[b + ADDR_W'(3)]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
         check("stream_pc", bus.inst_pc, exp_pc);
         check("stream_data", bus.inst_data, ref_word(exp_pc));
         last_pc = bus.inst_pc;
         hs_count++;
         exp_pc = exp_pc + 32'd4;
      end
      if (bus.redirect_valid) exp_pc = bus.redirect_pc & ~32'h3;
      if (rst) exp_pc = 32'h0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_valid(input string tag);
      int n;
      n = 0;
      while (bus.inst_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check(tag, bus.inst_valid, 1'b1);
   endtask

   task automatic redirect(input logic [31:0] pc);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pc;
      tick();
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      int streak;
      int n;
      int k;
      int h0;
      logic [ADDR_W-1:0] ea;

      rst = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      bus.inst_ready     = 1'b1;
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'($urandom);
      mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h56; mem[3] = 8'h78;
      mem[4] = 8'h9A; mem[5] = 8'hBC; mem[6] = 8'hDE; mem[7] = 8'hF0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("rst_mem_rd", bus.mem_rd, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 16'h0);
      check("rst_inst_valid", bus.inst_valid, 1'b0);
      check("rst_inst_data", bus.inst_data, 32'h0);
      check("rst_inst_pc", bus.inst_pc, 32'h0);
      check("rst_misalign", bus.misalign_err, 1'b0);

      // First fetch timing: reads at cycles 0..3, word visible at 5, next at 9
      rst = 1'b0;
      exp_pc = 32'h0;
      tick();
      check("c0_mem_rd", bus.mem_rd, 1'b1);
      check("c0_mem_addr", bus.mem_addr, 16'h0);
      repeat (4) tick();
      check("c4_valid", bus.inst_valid, 1'b0);
      tick();
      check("c5_valid", bus.inst_valid, 1'b1);
      check("c5_pc", bus.inst_pc, 32'h0);
      check("c5_data", bus.inst_data, 32'h12345678);
      repeat (3) tick();
      check("c8_valid", bus.inst_valid, 1'b0);
      tick();
      check("c9_valid", bus.inst_valid, 1'b1);
      check("c9_pc", bus.inst_pc, 32'h4);
      check("c9_data", bus.inst_data, 32'h9ABCDEF0);

      // Backpressure: buffer fills to DEPTH and fetching stops
      bus.inst_ready = 1'b0;
      repeat (20) tick();
      check("bp_mem_rd", bus.mem_rd, 1'b0);
      check("bp_valid", bus.inst_valid, 1'b1);
      bus.inst_ready = 1'b1;
      streak = 0;
      while (bus.inst_valid === 1'b1 && streak < 10) begin
         streak++;
         tick();
      end
      check("bp_buffered_words", streak, DEPTH);

      // Redirect while byte 2 of a word is being read
      n = 0;
      while (!(bus.mem_rd === 1'b1 && bus.mem_addr[1:0] == 2'd2) && n < 20) begin
         tick();
         n++;
      end
      check("byte2_found", bus.mem_addr[1:0], 2'd2);
      redirect(32'h100);
      check("rd1_valid", bus.inst_valid, 1'b0);
      check("rd1_mem_rd", bus.mem_rd, 1'b1);
      check("rd1_mem_addr", bus.mem_addr, 16'h0100);
      repeat (4) tick();
      check("rd5_valid", bus.inst_valid, 1'b0);
      tick();
      check("rd6_valid", bus.inst_valid, 1'b1);
      check("rd6_pc", bus.inst_pc, 32'h100);

      // Redirect in the same cycle as a completing handshake
      h0 = hs_count;
      redirect(32'h200);
      check("hs_redirect_consumed", hs_count - h0, 1);
      check("hs_redirect_empty", bus.inst_valid, 1'b0);
      wait_valid("hs_redirect_wait");
      check("hs_redirect_pc", bus.inst_pc, 32'h200);

      // Memory address and PC wrap
      redirect(32'h0000_FFFC);
      h0 = hs_count;
      k = 0;
      n = 0;
      while (k < 8 && n < 40) begin
         if (bus.mem_rd === 1'b1) begin
            ea = 16'hFFFC + 16'(k);
            check("wrap_addr", bus.mem_addr, ea);
            k++;
         end
         tick();
         n++;
      end
      check("wrap_reads", k, 8);
      n = 0;
      while (hs_count < h0 + 2 && n < 40) begin
         tick();
         n++;
      end
      check("wrap_second_pc", last_pc, 32'h0001_0000);

`ifdef IFETCH_ALIGN_CHECK_EN
      redirect(32'h102);
      check("mis_err_set", bus.misalign_err, 1'b1);
      check("mis_mem_rd", bus.mem_rd, 1'b0);
      check("mis_valid", bus.inst_valid, 1'b0);
      repeat (6) tick();
      check("mis_halt_mem_rd", bus.mem_rd, 1'b0);
      check("mis_halt_err", bus.misalign_err, 1'b1);
      redirect(32'h104);
      check("mis_err_clr", bus.misalign_err, 1'b0);
      check("mis_resume_rd", bus.mem_rd, 1'b1);
      check("mis_resume_addr", bus.mem_addr, 16'h0104);
      wait_valid("mis_resume_wait");
      check("mis_resume_pc", bus.inst_pc, 32'h104);
`else
      redirect(32'h102);
      check("noalign_err", bus.misalign_err, 1'b0);
      check("noalign_mem_rd", bus.mem_rd, 1'b1);
      check("noalign_addr", bus.mem_addr, 16'h0100);
      wait_valid("noalign_wait");
      check("noalign_pc", bus.inst_pc, 32'h100);
`endif

      // Randomized ready and redirects
      h0 = hs_count;
      for (int i = 0; i < 600; i++) begin
         bus.inst_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 49) == 0) begin
            redirect($urandom & ~32'h3);
            check("rand_redirect_flush", bus.inst_valid, 1'b0);
         end else begin
            tick();
         end
      end
      check("rand_progress", (hs_count - h0) > 40, 1'b1);

      // Reset in the middle of a word abandons it
      bus.inst_ready = 1'b1;
      n = 0;
      while (!(bus.mem_rd === 1'b1 && bus.mem_addr[1:0] == 2'd1) && n < 20) begin
         tick();
         n++;
      end
      rst = 1'b1;
      tick();
      check("midrst_valid", bus.inst_valid, 1'b0);
      check("midrst_mem_rd", bus.mem_rd, 1'b0);
      rst = 1'b0;
      wait_valid("midrst_wait");
      check("midrst_pc", bus.inst_pc, 32'h0);
      check("midrst_data", bus.inst_data, 32'h12345678);
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
